// File: rtl/encoder_out_fifo.sv
// rtl/encoder_out_fifo.sv - first-word-fall-through output buffer with complete-instruction counter
module encoder_out_fifo #(
  parameter int BUS_SIZE = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                syn_rst_n,
  input  logic [BUS_SIZE-1:0] din,
  input  logic                din_valid,
  input  logic                din_last,
  output logic                din_ready,
  output logic [BUS_SIZE-1:0] dout,
  output logic                dout_valid,
  output logic                dout_last,
  input  logic                dout_ready,
  output logic [AW:0]         level,
  output logic                pkt_pending
);

  localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  // Each entry carries the word plus its last flag in the top bit.
  logic [BUS_SIZE:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       level_q;
  logic [AW:0]       pkt_cnt;
  logic              push;
  logic              pop;
  logic              head_last;
  logic              pkt_inc;
  logic              pkt_dec;

  // Handshake flags depend on registered level only, so no ready/valid combinational loops.
  assign din_ready   = (level_q != FULL_LEVEL);
  assign dout_valid  = (level_q != '0);
  assign push        = din_valid & din_ready;
  assign pop         = dout_valid & dout_ready;

  // Head word falls through; last is masked so it reads 0 while the buffer is empty.
  assign {head_last, dout} = mem[rd_ptr];
  assign dout_last   = dout_valid & head_last;
  assign level       = level_q;
  assign pkt_pending = (pkt_cnt != '0);
  assign pkt_inc     = push & din_last;
  assign pkt_dec     = pop & head_last;

  // Storage write; contents survive reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {din_last, din};
    end
  end

  // Pointers, occupancy and complete-instruction count.
  always_ff @(posedge clk) begin
    if (!syn_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      pkt_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
      case ({pkt_inc, pkt_dec})
        2'b10:   pkt_cnt <= pkt_cnt + LVL_ONE;
        2'b01:   pkt_cnt <= pkt_cnt - LVL_ONE;
        default: pkt_cnt <= pkt_cnt;
      endcase
    end
  end

endmodule
